// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the nibble-serial 74181 ALU.
//   state_t     : sequencer states (IDLE, RUN, DONE)
//   S_ADD/S_SUB : 74181 arithmetic selects (use with m=0)
//   S_XOR       : 74181 logic select for A xor B (use with m=1)
//   k_width()   : width of the slice index counter, never below 1 bit
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] S_ADD = 4'b1001;  // A plus B (plus carry)
    localparam logic [3:0] S_SUB = 4'b0110;  // A minus B minus 1 (plus carry)
    localparam logic [3:0] S_XOR = 4'b0110;  // A xor B in logic mode

    function automatic int k_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/alu_74181.sv
// alu_74181 -- one 4-bit 74181 slice, active-high data convention.
//   a, b  : 4-bit operands
//   s, m  : function select / mode (1 = logic, 0 = arithmetic)
//   cn    : carry-in, active-low
//   f     : 4-bit result
//   cn4   : carry-out, active-low (computed in both modes)
//   aeqb  : A=B output, high when every F bit is 1
module alu_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4,
    output logic       aeqb
);
    logic [3:0] t_or;   // A | (B & S0) | (~B & S1)
    logic [3:0] t_and;  // (A & ~B & S2) | (A & B & S3); always a subset of t_or
    logic [4:0] sum;

    // Every arithmetic function of the part is t_or + t_and + carry; the logic
    // functions are the carry-free XNOR of the same two terms.
    always_comb begin
        t_or  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t_and = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum   = {1'b0, t_or} + {1'b0, t_and} + {4'b0000, ~cn};
        f     = m ? ~(t_or ^ t_and) : sum[3:0];
        cn4   = ~sum[4];
        aeqb  = &f;
    end

endmodule

// File: rtl/alu_74181_seq.sv
// alu_74181_seq -- nibble-serial ALU: one alu_74181 slice reused NIBBLES times.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake; a, b, s, m, cn captured on accept
//   out_valid/out_ready : result handshake; f, cn_out, equal held until taken
//   f                   : 4*NIBBLES-bit result
//   cn_out              : active-low carry-out of the top slice
//   equal               : AND of every slice's A=B output
//   zero                : result-is-zero in DONE when ALU_SEQ_ZERO_FLAG_EN is
//                         defined, otherwise tied to 0
module alu_74181_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [3:0]             s,
    input  logic                   m,
    input  logic                   cn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   f,
    output logic                   cn_out,
    output logic                   equal,
    output logic                   zero
);
    localparam int             KW     = k_width(NIBBLES);
    localparam logic [KW-1:0]  K_LAST = KW'(NIBBLES - 1);

    state_t               state_q;
    logic [4*NIBBLES-1:0] a_q, b_q, f_q;
    logic [3:0]           s_q;
    logic                 m_q;
    logic                 carry_q;  // doubles as cn_out once the last slice is done
    logic                 eq_q;
    logic [KW-1:0]        k_q;

    logic [3:0] slice_a, slice_b, slice_f;
    logic       slice_cn4, slice_eq;

    // NOTE: defaults first so no path through the loop leaves a value held,
    // which would otherwise infer a latch.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
    end

    alu_74181 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .s    (s_q),
        .m    (m_q),
        .cn   (carry_q),
        .f    (slice_f),
        .cn4  (slice_cn4),
        .aeqb (slice_eq)
    );

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            k_q     <= '0;
            f_q     <= '0;
            carry_q <= 1'b1;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        s_q     <= s;
                        m_q     <= m;
                        k_q     <= '0;
                        f_q     <= '0;
                        carry_q <= cn;    // slice 0 takes the captured carry-in
                        eq_q    <= 1'b1;  // identity for the AND accumulation
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k_q == KW'(i)) begin
                            f_q[4*i +: 4] <= slice_f;
                        end
                    end
                    carry_q <= slice_cn4;
                    eq_q    <= eq_q & slice_eq;
                    // k holds on the last slice so it never wraps mid-operation.
                    if (k_q == K_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign f         = f_q;
    assign cn_out    = carry_q;
    assign equal     = eq_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign zero = (state_q == ST_DONE) && (f_q == '0);
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_74181_seq.sv
// tb_alu_74181_seq -- directed, self-checking bench for alu_74181_seq
// (NIBBLES = 4). Expected values are hand-computed from the 74181 tables.
module tb_alu_74181_seq;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    localparam logic ZF_EN = 1'b1;
`else
    localparam logic ZF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        cn_out, equal, zero;

    int total  = 0;
    int passed = 0;

    alu_74181_seq #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cn        (cn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cn_out    (cn_out),
        .equal     (equal),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns #1 after the accepting edge; the
    // operand inputs are then scrambled to show RUN ignores them.
    task automatic start_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic [3:0] ts, input logic tm, input logic tcn);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; s = ts; m = tm; cn = tcn;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a  = 16'($urandom);
        b  = 16'($urandom);
        s  = 4'($urandom);
        m  = 1'($urandom);
        cn = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd4);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [3:0] ts, input logic tm, input logic tcn,
                          input logic [15:0] ef, input logic ecn, input logic eeq,
                          input logic ez);
        start_op(tag, ta, tb_, ts, tm, tcn);
        check({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
        wait_done(tag);
        check({tag, ".f"},        32'(f),        32'(ef));
        check({tag, ".cn_out"},   32'(cn_out),   32'(ecn));
        check({tag, ".equal"},    32'(equal),    32'(eeq));
        check({tag, ".zero"},     32'(zero),     32'(ez));
        check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1;

        // Reset values while rst is held.
        #12;
        check("rst.f",         32'(f),         32'h0);
        check("rst.cn_out",    32'(cn_out),    32'd1);
        check("rst.equal",     32'(equal),     32'd0);
        check("rst.zero",      32'(zero),      32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD 0x1234 + 0x1111 = 0x2345, no carry.
        run_op("add", 16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1, 16'h2345, 1'b1, 1'b0, 1'b0);

        // ADD overflow 0xFFFF + 1 = 0x0000, carry out (active-low -> 0).
        run_op("ovf", 16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, ZF_EN);

        // Compare via A-B-1: equal operands give all ones.
        run_op("cmp_eq", 16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        run_op("cmp_ne", 16'h5A5A, 16'h5A5B, S_SUB, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // True subtract with carry-in asserted: 0x1000 - 1 = 0x0FFF, no borrow.
        run_op("sub", 16'h1000, 16'h0001, S_SUB, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // XOR with backpressure; in_valid held high in DONE must be ignored.
        start_op("xor", 16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1);
        wait_done("xor");
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("xor.f_hold",     32'(f),         32'h0FF0);
            check("xor.valid_hold", 32'(out_valid), 32'd1);
            check("xor.ready_hold", 32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        check("xor.f",      32'(f),      32'h0FF0);
        check("xor.cn_out", 32'(cn_out), 32'd1);
        check("xor.equal",  32'(equal),  32'd0);
        in_valid = 1'b0;
        handshake("xor");

        // Reset while RUN sits at k=2, then a clean ADD.
        start_op("abort", 16'h5555, 16'h5555, S_ADD, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.f",         32'(f),         32'h0);
        check("abort.in_ready",  32'(in_ready),  32'd0);
        check("abort.cn_out",    32'(cn_out),    32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort.idle_ready", 32'(in_ready),  32'd1);
        check("abort.idle_valid", 32'(out_valid), 32'd0);
        check("abort.idle_f",     32'(f),         32'h0);
        run_op("post", 16'h0001, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
